// File: rtl/nios2_mult_pkg.sv
// Shared types and elaboration helpers for the Nios II iterative multiplier.
package nios2_mult_pkg;

  typedef enum logic [1:0] {
    ModeMul    = 2'b00,
    ModeMulxuu = 2'b01,
    ModeMulxsu = 2'b10,
    ModeMulxss = 2'b11
  } mult_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StFix,
    StDone
  } mult_state_e;

  function automatic bit mult_params_ok(input int unsigned data_w, input int unsigned slice_w);
    return (slice_w >= 8) && (data_w % slice_w == 0);
  endfunction

endpackage

// File: rtl/nios2_mult_pp.sv
// Unsigned SLICE_W x SLICE_W partial multiplier; isolated so it maps onto one DSP block.
module nios2_mult_pp #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   a,
  input  logic [SLICE_W-1:0]   b,
  output logic [2*SLICE_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/nios2_mult_unit.sv
// Iterative signed/unsigned multiplier: one partial product per cycle, shift-accumulated
// into a full-width accumulator, sign-fixed, then the requested half is returned.
module nios2_mult_unit
  import nios2_mult_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy
);

  localparam int unsigned N     = DATA_W / SLICE_W;
  localparam int unsigned P     = N * N;
  localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W;

  if (!mult_params_ok(DATA_W, SLICE_W)) begin : g_param_check
    $error("nios2_mult_unit: DATA_W must be a multiple of SLICE_W and SLICE_W >= 8");
  end

  mult_state_e       state_q, state_d;
  mult_mode_e        mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] mag_a_q, mag_a_d;
  logic [DATA_W-1:0] mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  mult_mode_e          mode_in;
  logic                accept;
  logic                sign_a, sign_b;
  logic [IDX_W-1:0]    slice_i, slice_j;
  logic [SLICE_W-1:0]  a_slice, b_slice;
  logic [2*SLICE_W-1:0] pp;
  logic [ACC_W-1:0]    pp_shifted;
  logic [ACC_W-1:0]    acc_fix;

  assign mode_in  = mult_mode_e'(in_mode);
  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != StIdle);

  // MUL only returns the low half, which is identical for any signedness.
  assign sign_a = ((mode_in == ModeMulxsu) | (mode_in == ModeMulxss)) & in_src1[DATA_W-1];
  assign sign_b = (mode_in == ModeMulxss) & in_src2[DATA_W-1];

  always_comb begin
    slice_i    = IDX_W'(32'(idx_q) / N);
    slice_j    = IDX_W'(32'(idx_q) % N);
    a_slice    = mag_a_q[slice_i*SLICE_W +: SLICE_W];
    b_slice    = mag_b_q[slice_j*SLICE_W +: SLICE_W];
    pp_shifted = ACC_W'(pp) << (SLICE_W * (32'(slice_i) + 32'(slice_j)));
    acc_fix    = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
  end

  nios2_mult_pp #(
    .SLICE_W(SLICE_W)
  ) u_pp (
    .a(a_slice),
    .b(b_slice),
    .p(pp)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: ;
      StMul: begin
        acc_d = acc_q + pp_shifted;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(P - 1)) state_d = StFix;
      end
      StFix: begin
        acc_d    = acc_fix;
        result_d = (mode_q == ModeMul) ? acc_fix[DATA_W-1:0] : acc_fix[ACC_W-1:DATA_W];
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept is only possible from IDLE or a completing DONE, so it overrides the above.
    if (accept) begin
      mode_d  = mode_in;
      mag_a_d = sign_a ? (~in_src1 + DATA_W'(1)) : in_src1;
      mag_b_d = sign_b ? (~in_src2 + DATA_W'(1)) : in_src2;
      neg_d   = sign_a ^ sign_b;
      acc_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      state_d = StMul;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= ModeMul;
      idx_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;

endmodule

// File: tb/tb_nios2_mult_unit.sv
// Directed bench for nios2_mult_unit (32/16) plus a random regression on a 64/16 instance.
module tb_nios2_mult_unit;
  import nios2_mult_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'b00;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        busy;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [1:0]  w_in_mode = 2'b00;
  logic [63:0] w_src1 = '0;
  logic [63:0] w_src2 = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [63:0] w_out_result;
  logic        w_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  nios2_mult_unit #(.DATA_W(32), .SLICE_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_src1(in_src1), .in_src2(in_src2), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  nios2_mult_unit #(.DATA_W(64), .SLICE_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_mode(w_in_mode), .in_src1(w_src1), .in_src2(w_src2), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_result(w_out_result), .busy(w_busy)
  );

  task automatic issue32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    in_mode = m; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_src1 = '1; in_src2 = '1;
  endtask

  task automatic wait_valid32(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/ready %b want 001", {out_valid, busy, in_ready});
    end
    checks++;
    if (out_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h want 00000000", out_result);
    end
    reset = 1'b0;
  endtask

  task automatic test_modes();
    int lat;
    vecs[0] = '{ModeMul,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1] = '{ModeMulxss, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[2] = '{ModeMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3] = '{ModeMul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4] = '{ModeMulxsu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5] = '{ModeMulxss, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[6] = '{ModeMulxsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{ModeMulxuu, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      issue32(vecs[k].m, vecs[k].a, vecs[k].b);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_%0d: got busy %b ready %b want 1 0", k, busy, in_ready);
      end
      wait_valid32(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL latency_%0d: got %0d edges want 5", k, lat);
      end
      checks++;
      if (out_result !== vecs[k].r) begin
        errors++;
        $display("FAIL result_%0d: got %h want %h", k, out_result, vecs[k].r);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] snap;
    out_ready = 1'b0;
    issue32(ModeMul, 32'h0001_0003, 32'h0002_0005);
    wait_valid32(lat);
    snap = out_result;
    checks++;
    if (lat !== 5 || snap !== 32'h000B_000F) begin
      errors++;
      $display("FAIL bp_first: got lat %0d result %h want 5 000b000f", lat, snap);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== snap) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid %b ready %b result %h want 1 0 %h",
                 c, out_valid, in_ready, out_result, snap);
      end
    end
    out_ready = 1'b1;
    issue32(ModeMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_handoff: got valid %b busy %b want 0 1", out_valid, busy);
    end
    wait_valid32(lat);
    checks++;
    if (lat !== 5 || out_result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL bp_second: got lat %0d result %h want 5 fffffffe", lat, out_result);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid %b busy %b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp_r [3];
    logic [31:0] opa [3];
    exp_r[0] = 32'h0000_0006; exp_r[1] = 32'h0000_0063; exp_r[2] = 32'hFFFF_FFF1;
    opa[0] = 32'h0000_0002; opa[1] = 32'h0000_0021; opa[2] = 32'hFFFF_FFFB;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      // Each new op is offered in the DONE cycle of the previous one.
      issue32(ModeMul, opa[k], 32'h0000_0003);
      wait_valid32(lat);
      checks++;
      if (lat !== 5 || out_result !== exp_r[k]) begin
        errors++;
        $display("FAIL b2b_%0d: got lat %0d result %h want 5 %h", k, lat, out_result, exp_r[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int seen;
    out_ready = 1'b1;
    issue32(ModeMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL midreset_state: got busy %b ready %b valid %b result %h want 0 1 0 0",
               busy, in_ready, out_valid, out_result);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_valid: got %0d valid cycles want 0", seen);
    end
  endtask

  function automatic logic [63:0] ref64(input logic [1:0] m, input logic [63:0] a,
                                        input logic [63:0] b);
    logic sa, sb;
    logic signed [127:0] ea, eb, full;
    sa = ((m == ModeMulxsu) || (m == ModeMulxss)) && a[63];
    sb = (m == ModeMulxss) && b[63];
    ea = {{64{sa}}, a};
    eb = {{64{sb}}, b};
    full = ea * eb;
    return (m == ModeMul) ? full[63:0] : full[127:64];
  endfunction

  task automatic test_wide64();
    int lat;
    logic [1:0] m;
    logic [63:0] a, b, exp_r;
    w_out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      m = 2'(k % 4);
      if (k < 4) begin
        a = 64'h8000_0000_0000_0000;
        b = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      exp_r = ref64(m, a, b);
      w_in_mode = m; w_src1 = a; w_src2 = b; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      lat = 0;
      while (!w_out_valid && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 17 || w_out_result !== exp_r) begin
        errors++;
        $display("FAIL wide_%0d: got lat %0d result %h want 17 %h", k, lat, w_out_result, exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_wide64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
